// File: rtl/mlp_layer_scheduler.sv
// mlp_layer_scheduler: sequences input load, N x N fully connected layers over
// ping-pong activation buffers, and the final drain to the output stream.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | writing the input vector into buf1
// ACCUM | streaming one neuron's inputs and weights into the MAC
// WAIT  | waiting for the MAC result, then writing it into dst
// SWAP  | exchanging buffer roles between layers
// DRAIN | streaming the final vector out of src
// DONE  | one-cycle completion pulse
module mlp_layer_scheduler #(
  parameter int N      = 256,
  parameter int LAYERS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        mac_valid,
  output logic        wr_en1,
  output logic        rd_en1,
  output logic        wr_en2,
  output logic        rd_en2,
  output logic        demux_sel,
  output logic        mux_sel,
  output logic [7:0]  write_addr,
  output logic [7:0]  read_addr,
  output logic [19:0] weight_addr,
  output logic        mac_en,
  output logic        mac_clr,
  output logic        mac_last,
  output logic [3:0]  layer_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAST       = 8'(N - 1);
  localparam logic [3:0] LAST_LAYER = 4'(LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACCUM, S_WAIT, S_SWAP, S_DRAIN, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] i_cnt, j_cnt, k_cnt;
  logic [3:0] layer_cnt;
  logic       src;

  // Counters wrap at N-1 rather than at their natural 8-bit limit.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v);
    return (v == LAST) ? 8'd0 : v + 8'd1;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (in_valid && k_cnt == LAST) state_nxt = S_ACCUM;
      S_ACCUM: if (i_cnt == LAST) state_nxt = S_WAIT;
      S_WAIT:  if (mac_valid) state_nxt = (j_cnt == LAST) ? S_SWAP : S_ACCUM;
      S_SWAP:  state_nxt = (layer_cnt == LAST_LAYER) ? S_DRAIN : S_ACCUM;
      S_DRAIN: if (out_ready && k_cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Index counters, layer counter and buffer-role flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      layer_cnt <= '0;
      src       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          i_cnt     <= '0;
          j_cnt     <= '0;
          k_cnt     <= '0;
          layer_cnt <= '0;
          src       <= 1'b0;
        end
        S_LOAD:  if (in_valid) k_cnt <= wrap_inc(k_cnt);
        S_ACCUM: i_cnt <= wrap_inc(i_cnt);
        S_WAIT:  if (mac_valid) j_cnt <= wrap_inc(j_cnt);
        S_SWAP: begin
          src   <= ~src;
          k_cnt <= '0;
          if (layer_cnt != LAST_LAYER) layer_cnt <= layer_cnt + 4'd1;
        end
        S_DRAIN: if (out_ready) k_cnt <= wrap_inc(k_cnt);
        default: ;
      endcase
    end
  end

  // Output decode; everything is held at 0 while reset is asserted so no
  // strobe can escape during the reset cycle.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    wr_en1      = 1'b0;
    rd_en1      = 1'b0;
    wr_en2      = 1'b0;
    rd_en2      = 1'b0;
    demux_sel   = 1'b0;
    mux_sel     = 1'b0;
    write_addr  = '0;
    read_addr   = '0;
    weight_addr = '0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    mac_last    = 1'b0;
    layer_idx   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    if (rst) begin
      layer_idx = layer_cnt;
      busy      = (state != S_IDLE);
      case (state)
        S_LOAD: begin
          in_ready   = 1'b1;
          write_addr = k_cnt;
          wr_en1     = in_valid;
        end
        S_ACCUM: begin
          read_addr   = i_cnt;
          mux_sel     = src;
          rd_en1      = ~src;
          rd_en2      = src;
          mac_en      = 1'b1;
          mac_clr     = (i_cnt == 8'd0);
          mac_last    = (i_cnt == LAST);
          weight_addr = {layer_cnt, j_cnt, i_cnt};
        end
        S_WAIT: if (mac_valid) begin
          demux_sel  = ~src;
          wr_en1     = src;
          wr_en2     = ~src;
          write_addr = j_cnt;
        end
        S_DRAIN: begin
          read_addr = k_cnt;
          mux_sel   = src;
          rd_en1    = ~src;
          rd_en2    = src;
          out_valid = 1'b1;
        end
        S_DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mlp_layer_scheduler.md
# mlp_layer_scheduler

Sequencer for the MLP ping-pong activation buffers and the shared MAC datapath. It loads an input vector into buffer 1 and runs LAYERS fully connected layers. Each layer reads activations from one buffer, streams weight addresses and MAC controls, and writes each neuron result into the other buffer. The buffers then swap roles, and after the last layer the final vector is drained to the output stream. It sits between the top-level start/stream interface and the buffer/MAC datapath.

## Interface
- N, 256, neurons per layer (equals input width); legal 2..256
- LAYERS, 2, number of layers; legal 1..15
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin run; sampled only in IDLE
- in_valid / in_ready  in / out  1 / 1  input-vector handshake
- out_valid / out_ready  out / in  1 / 1  result-vector handshake
- mac_valid  in  1  MAC result ready (arbitrary latency after mac_last)
- wr_en1, rd_en1, wr_en2, rd_en2  out  1 each  buffer strobes
- demux_sel  out  1  write target: 0 = buf1, 1 = buf2
- mux_sel  out  1  read source to MAC/output: 0 = buf1, 1 = buf2
- write_addr, read_addr  out  8 each  buffer addresses
- weight_addr  out  20  {layer_idx, j, i}
- mac_en, mac_clr, mac_last  out  1 each  MAC controls
- layer_idx  out  4  current layer
- busy, done  out  1 each  run active / 1-cycle completion pulse

## Operation
- Counters:
  - i = input index.
  - j = neuron index.
  - k = load/drain index.
  - All are 8-bit and wrap to 0 at N-1, never at 255.
- src: buffer read by the current layer. Dst is always the other buffer (~src).
- All outputs are combinational from state and counters; all strobes are 0 outside the states that assert them.
- IDLE:
  - busy = 0.
  - A start pulse moves to LOAD with k = 0, layer_idx = 0, src = 0.
- LOAD:
  - Drives in_ready = 1, busy = 1, demux_sel = 0, write_addr = k, wr_en1 = in_valid.
  - Each in_valid & in_ready increments k.
  - The accept with k = N-1 moves to ACCUM.
- ACCUM, one input per cycle:
  - Drives read_addr = i, mux_sel = src, rd_en of src, mac_en = 1.
  - Drives mac_clr = (i == 0), mac_last = (i == N-1), weight_addr = {layer_idx, j, i}.
  - At i = N-1, moves to WAIT.
- WAIT:
  - Holds all strobes at 0 until mac_valid.
  - In the mac_valid cycle it drives demux_sel = dst, wr_en of dst = 1, write_addr = j.
  - If j < N-1: increments j and returns to ACCUM.
  - Else: j = 0 and moves to SWAP.
- SWAP, one cycle:
  - src toggles.
  - If layer_idx == LAYERS-1, moves to DRAIN with k = 0.
  - Else increments layer_idx and moves to ACCUM.
- DRAIN:
  - Drives rd_en of src, mux_sel = src, read_addr = k, out_valid = 1.
  - The buffers have combinational read, so data is valid in the same cycle.
  - k advances on out_ready.
  - The handshake with k = N-1 moves to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Final result location: buf2 if LAYERS is odd, buf1 if LAYERS is even.
- start is ignored while busy = 1.
- mac_valid is ignored outside WAIT.

## Timing
- Reset (rst = 0 at an edge):
  - State returns to IDLE and all counters, src and layer_idx clear to 0.
  - All outputs read 0, including mux_sel, demux_sel and addresses.
  - This applies from any state, mid-run included; no write strobe is issued in the reset cycle or the following cycle.
- start → LOAD is registered: in_ready rises the cycle after start.
- Per neuron: N ACCUM cycles + (mac latency + 1) WAIT cycles.
- SWAP adds 1 cycle per layer.
- DRAIN takes N cycles with out_ready held high.
- done rises exactly one cycle after the last out handshake; busy falls with the DONE→IDLE transition.
- Minimum total, with MAC latency L and no stalls: 1 + N + LAYERS·(N·(N+L+1) + 1) + N + 1 cycles.

## Test plan
- Reset values:
  - Stimulus: hold rst = 0 for 3 cycles, then release with start = 0.
  - Required: all outputs 0 and the block stays in IDLE.
  - Stimulus: assert rst = 0 in the middle of ACCUM of layer 1.
  - Required: the next cycle shows busy = 0, mux_sel = 0, and no wr_en.
- Load with gaps:
  - Stimulus: N = 4; in_valid pattern 1,0,1,1,0,1.
  - Required: wr_en1 on the four accepts only, write_addr 0,1,2,3; ACCUM entered right after the 4th accept.
- Single layer, N = 4, LAYERS = 1, mac_valid 3 cycles after mac_last:
  - Required: mac_clr at i = 0 only; mac_last at i = 3.
  - Required: weight_addr 0x00000..0x00003, then 0x00100...
  - Required: wr_en2 with write_addr = j = 0..3.
  - Required: DRAIN reads buf2 (mux_sel = 1).
- Ping-pong, N = 2, LAYERS = 2:
  - Required mux_sel per layer: 0, then 1.
  - Required demux_sel per layer: 1, then 0.
  - Required: DRAIN reads buf1 (mux_sel = 0); layer_idx reads 0, then 1.
- Drain backpressure:
  - Stimulus: out_ready pattern 0,1,0,0,1,1,1.
  - Required: read_addr holds while out_ready = 0 and steps 0..3; done is one pulse after the k = 3 handshake.
- Start during busy:
  - Stimulus: pulse start during WAIT.
  - Required: no state change; the run completes with exactly one done pulse.
